// File: rtl/dffq_ctrl_pkg.sv
// Shared types and helpers for the dffq scan-chain shift controller.
package dffq_ctrl_pkg;

    // Controller phases: idle, one-cycle functional capture, serial shift, completion pulse
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Smallest legal chain length
    localparam int MIN_CHAIN_LEN = 2;

    // Width of the shift down-counter: it must hold CHAIN_LEN-1, never narrower than one bit
    function automatic int cnt_width(input int chain_len);
        if (chain_len <= MIN_CHAIN_LEN) begin
            return 1;
        end
        return $clog2(chain_len);
    endfunction

endpackage

// File: rtl/dffq_chain_bit_counter.sv
// Loadable down-counter tracking the remaining shift cycles of the chain.
// The terminal-count flag is a pure decode of the registered count.
module dffq_chain_bit_counter
    import dffq_ctrl_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; the count saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count: the current shift cycle is the last one
    always_comb begin
        tc = (cnt_q == '0);
    end

endmodule

// File: rtl/dffq_chain_shift_ctrl.sv
// Sequencer for a serial dffq scan chain: optional functional capture, then
// CHAIN_LEN shift cycles streaming scan_in into the chain and so_chain out.
// Owns the chain's scan-enable and clock-enable; start/done toward the port.
module dffq_chain_shift_ctrl
    import dffq_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic CLK,
    input  logic RN,
    input  logic start,
    input  logic capture_en,
    input  logic pause,
    input  logic abort,
    input  logic scan_in,
    input  logic so_chain,
    output logic se,
    output logic ce,
    output logic si_chain,
    output logic scan_out,
    output logic scan_out_vld,
    output logic busy,
    output logic done,
    output logic aborted
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CHAIN_LEN - 1);

    state_t state_q;
    state_t state_d;
    logic   scan_out_q;
    logic   scan_out_d;
    logic   scan_out_vld_q;
    logic   scan_out_vld_d;
    logic   aborted_q;
    logic   aborted_d;
    logic   cnt_load;
    logic   cnt_en;
    logic   cnt_tc;

    // Remaining-shift counter, loaded with CHAIN_LEN-1 when a start is accepted
    dffq_chain_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .CLK      (CLK),
        .RN       (RN),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    // Next-state and datapath updates; abort outranks pause and the terminal count
    always_comb begin
        state_d        = state_q;
        scan_out_d     = scan_out_q;
        scan_out_vld_d = 1'b0;
        aborted_d      = aborted_q;
        cnt_load       = 1'b0;
        cnt_en         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load  = 1'b1;
                    aborted_d = 1'b0;
                    state_d   = capture_en ? CAPTURE : SHIFT;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (!pause) begin
                    cnt_en         = 1'b1;
                    scan_out_d     = so_chain;
                    scan_out_vld_d = 1'b1;
                    if (cnt_tc) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers, all cleared asynchronously
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q        <= IDLE;
            scan_out_q     <= 1'b0;
            scan_out_vld_q <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            scan_out_q     <= scan_out_d;
            scan_out_vld_q <= scan_out_vld_d;
            aborted_q      <= aborted_d;
        end
    end

    // Chain controls decoded from the registered state, plus pause for ce and scan_in for si
    always_comb begin
        se       = (state_q == SHIFT);
        ce       = (state_q == CAPTURE) || ((state_q == SHIFT) && !pause);
        si_chain = (state_q == SHIFT) ? scan_in : 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // Registered status outputs
    always_comb begin
        scan_out     = scan_out_q;
        scan_out_vld = scan_out_vld_q;
        aborted      = aborted_q;
    end

endmodule

// File: tb/tb_dffq_chain_shift_ctrl.sv
// Directed bench for dffq_chain_shift_ctrl with a 4-flop chain model.
module tb_dffq_chain_shift_ctrl;

    localparam int CHAIN_LEN = 4;

    logic CLK = 1'b0;
    logic RN;
    logic start, capture_en, pause, abort, scan_in;
    logic so_chain;
    logic se, ce, si_chain, scan_out, scan_out_vld, busy, done, aborted;

    logic [3:0] chain = 4'b0000;
    logic [3:0] func_d;
    logic [3:0] preset_val;
    logic       preset_req;

    int checks = 0;
    int errors = 0;

    // in = {start, capture_en, pause, abort, scan_in}
    // ex = {se, ce, si_chain, busy, done, scan_out_vld, aborted, check_so, scan_out}
    typedef struct packed {
        logic [4:0] in;
        logic [8:0] ex;
    } vec_t;

    vec_t vecs[$];

    dffq_chain_shift_ctrl #(
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .CLK          (CLK),
        .RN           (RN),
        .start        (start),
        .capture_en   (capture_en),
        .pause        (pause),
        .abort        (abort),
        .scan_in      (scan_in),
        .so_chain     (so_chain),
        .se           (se),
        .ce           (ce),
        .si_chain     (si_chain),
        .scan_out     (scan_out),
        .scan_out_vld (scan_out_vld),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 CLK = ~CLK;

    // Behavioural scan chain: capture func_d when se=0, shift toward MSB when se=1
    always @(posedge CLK) begin
        if (preset_req) begin
            chain <= preset_val;
        end else if (ce) begin
            chain <= se ? {chain[2:0], si_chain} : func_d;
        end
    end

    assign so_chain = chain[3];

    task automatic addV(input logic [4:0] in, input logic [8:0] ex);
        vec_t v;
        v.in = in;
        v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        {start, capture_en, pause, abort, scan_in} = v.in;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Apply vectors lo..hi, one per cycle, sampling at negedge + 1
    task automatic runSeg(input string seg, input int lo, input int hi);
        logic [8:0] got;
        for (int i = lo; i <= hi; i++) begin
            @(negedge CLK);
            applyStimulus(vecs[i]);
            #1;
            got = {se, ce, si_chain, busy, done, scan_out_vld, aborted,
                   vecs[i].ex[1], scan_out & vecs[i].ex[1]};
            checkOutput($sformatf("%s[%0d]", seg, i - lo), got, vecs[i].ex);
        end
    endtask

    task automatic presetChain(input logic [3:0] v);
        @(negedge CLK);
        preset_val = v;
        preset_req = 1'b1;
        @(negedge CLK);
        preset_req = 1'b0;
    endtask

    function automatic logic [8:0] allOuts();
        return {se, ce, si_chain, busy, done, scan_out_vld, aborted, scan_out, 1'b0};
    endfunction

    initial begin
        int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi, e_lo, e_hi, f_lo, f_hi;

        // A: capture then shift, func_d=1001, scan_in=0
        a_lo = vecs.size();
        addV(5'b11001, 9'b0000000_00);
        addV(5'b00001, 9'b0101000_00);
        addV(5'b00000, 9'b1101000_00);
        addV(5'b00000, 9'b1101010_11);
        addV(5'b00000, 9'b1101010_10);
        addV(5'b00000, 9'b1101010_10);
        addV(5'b00000, 9'b0001110_11);
        addV(5'b00000, 9'b0000000_11);
        a_hi = vecs.size() - 1;
        // B: shift only, chain preset 0110, scan_in 1,0,1,1
        b_lo = vecs.size();
        addV(5'b10000, 9'b0000000_00);
        addV(5'b00001, 9'b1111000_00);
        addV(5'b00000, 9'b1101010_10);
        addV(5'b00001, 9'b1111010_11);
        addV(5'b00001, 9'b1111010_11);
        addV(5'b00001, 9'b0001110_10);
        addV(5'b00000, 9'b0000000_10);
        b_hi = vecs.size() - 1;
        // C: pause for three cycles after the first shift, chain preset 1100
        c_lo = vecs.size();
        addV(5'b10000, 9'b0000000_00);
        addV(5'b00000, 9'b1101000_00);
        addV(5'b00100, 9'b1001010_11);
        addV(5'b00100, 9'b1001000_11);
        addV(5'b00100, 9'b1001000_11);
        addV(5'b00000, 9'b1101000_11);
        addV(5'b00000, 9'b1101010_11);
        addV(5'b00000, 9'b1101010_10);
        addV(5'b00000, 9'b0001110_10);
        addV(5'b00000, 9'b0000000_10);
        c_hi = vecs.size() - 1;
        // D: pause on the terminal-count cycle defers DONE
        d_lo = vecs.size();
        addV(5'b10000, 9'b0000000_00);
        addV(5'b00000, 9'b1101000_00);
        addV(5'b00000, 9'b1101010_00);
        addV(5'b00000, 9'b1101010_00);
        addV(5'b00100, 9'b1001010_00);
        addV(5'b00100, 9'b1001000_00);
        addV(5'b00000, 9'b1101000_00);
        addV(5'b00000, 9'b0001110_00);
        addV(5'b00000, 9'b0000000_00);
        d_hi = vecs.size() - 1;
        // E: start while busy and during DONE is ignored
        e_lo = vecs.size();
        addV(5'b10000, 9'b0000000_00);
        addV(5'b10000, 9'b1101000_00);
        addV(5'b11000, 9'b1101010_00);
        addV(5'b00000, 9'b1101010_00);
        addV(5'b00000, 9'b1101010_00);
        addV(5'b11000, 9'b0001110_00);
        addV(5'b00000, 9'b0000000_00);
        addV(5'b00000, 9'b0000000_00);
        e_hi = vecs.size() - 1;
        // F: abort in second shift cycle, abort in IDLE, restart clears aborted, abort again
        f_lo = vecs.size();
        addV(5'b10000, 9'b0000000_00);
        addV(5'b00000, 9'b1101000_00);
        addV(5'b00010, 9'b1101010_00);
        addV(5'b00000, 9'b0000001_00);
        addV(5'b00010, 9'b0000001_00);
        addV(5'b00000, 9'b0000001_00);
        addV(5'b11000, 9'b0000001_00);
        addV(5'b00000, 9'b0101000_00);
        addV(5'b00010, 9'b1101000_00);
        addV(5'b00000, 9'b0000001_00);
        f_hi = vecs.size() - 1;

        RN         = 1'b0;
        start      = 1'b0;
        capture_en = 1'b0;
        pause      = 1'b0;
        abort      = 1'b0;
        scan_in    = 1'b0;
        preset_req = 1'b0;
        preset_val = 4'b0000;
        func_d     = 4'b1001;

        #12;
        checkOutput("reset_state", allOuts(), 9'b0);
        @(negedge CLK);
        RN = 1'b1;

        runSeg("capture", a_lo, a_hi);
        presetChain(4'b0110);
        runSeg("shift_only", b_lo, b_hi);
        checks++;
        if (chain !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL chain_after_shift: got %b expected %b", chain, 4'b1011);
        end
        presetChain(4'b1100);
        runSeg("pause", c_lo, c_hi);
        runSeg("pause_tc", d_lo, d_hi);
        runSeg("start_busy", e_lo, e_hi);
        runSeg("abort", f_lo, f_hi);

        // Asynchronous reset in the middle of a shift
        presetChain(4'b1111);
        @(negedge CLK);
        {start, capture_en, pause, abort, scan_in} = 5'b10001;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        #1;
        checkOutput("pre_reset_shift", allOuts(), 9'b1111010_10);
        #1;
        RN = 1'b0;
        #1;
        checkOutput("async_reset", allOuts(), 9'b0);
        @(negedge CLK);
        #1;
        checkOutput("reset_held", allOuts(), 9'b0);
        scan_in = 1'b0;
        RN      = 1'b1;
        runSeg("after_reset", a_lo, a_hi);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
